// File: rtl/usb_frame_streamer_if.sv
// FT600-style FIFO bridge strobes shared between the frame streamer and the USB bridge.
// The 16-bit DATA and 2-bit BE lines are bidirectional and stay plain module ports.
interface usb_frame_streamer_if;
    logic TXE_N;
    logic RXF_N;
    logic OE_N;
    logic RD_N;
    logic WR_N;

    modport master (
        input  TXE_N,
        input  RXF_N,
        output OE_N,
        output RD_N,
        output WR_N
    );

    modport slave (
        output TXE_N,
        output RXF_N,
        input  OE_N,
        input  RD_N,
        input  WR_N
    );
endinterface

// File: rtl/usb_frame_streamer.sv
// Captures DEPTH samples per channel, then streams one framed burst over a 16-bit FIFO bus
// with TXE_N back-pressure. Host command words are read through RXF_N while not sending.
module usb_frame_streamer #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned HEADER_EN = 1,
    parameter logic [15:0] HEADER    = 16'hA5A5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_sending,
    input  logic [NUM_CH*SAMPLE_W-1:0]   data_in,
    output logic [$clog2(DEPTH)-1:0]     read_index,
    output logic [15:0]                  command,
    output logic                         command_valid,
    output logic                         busy,
    output logic                         frame_done,
    usb_frame_streamer_if.master         bus,
    inout  wire  [15:0]                  DATA,
    inout  wire  [1:0]                   BE
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_CH * DEPTH + 1) + 1;
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(HEADER_EN + NUM_CH * DEPTH - 1);
    localparam logic [CNT_W-1:0] HDR_OFS  = CNT_W'(HEADER_EN);

    typedef enum logic [3:0] {
        StIdle,
        StCapture,
        StReady,
        StRdOe,
        StRdRd,
        StRdCap,
        StRdEnd,
        StSend,
        StHold
    } state_e;

    state_e             state_q;
    logic               start_q;
    logic               pending_q;
    logic [IDX_W-1:0]   read_index_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic [15:0]        tx_word_q;
    logic [15:0]        rx_word_q;
    logic [15:0]        command_q;
    logic               command_valid_q;
    logic               frame_done_q;
    logic               oe_n_q;
    logic               rd_n_q;
    logic               wr_n_q;

    logic [SAMPLE_W-1:0] sample_buf [NUM_CH][DEPTH];

    logic               start_edge;
    logic [CNT_W-1:0]   next_pos;
    logic [CNT_W-1:0]   pay_pos;
    logic [CH_W-1:0]    next_ch;
    logic [IDX_W-1:0]   next_idx;
    logic [15:0]        next_word;

    assign start_edge = start_sending & ~start_q;

    // Word presented after the current one; position 0 while still in READY.
    always_comb begin
        next_pos  = (state_q == StSend) ? word_cnt_q + CNT_W'(1) : '0;
        pay_pos   = next_pos - HDR_OFS;
        next_ch   = CH_W'(pay_pos >> IDX_W);
        next_idx  = ~pay_pos[IDX_W-1:0];
        next_word = 16'(sample_buf[next_ch][next_idx]);
        if ((HEADER_EN != 0) && (next_pos == '0)) begin
            next_word = HEADER;
        end
    end

    // Sample buffers carry no reset so stale contents survive between frames.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_capture
        always_ff @(posedge clk) begin
            if (state_q == StCapture) begin
                sample_buf[k][read_index_q] <= data_in[k*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            start_q         <= 1'b0;
            pending_q       <= 1'b0;
            read_index_q    <= '0;
            word_cnt_q      <= '0;
            tx_word_q       <= '0;
            rx_word_q       <= '0;
            command_q       <= '0;
            command_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            oe_n_q          <= 1'b1;
            rd_n_q          <= 1'b1;
            wr_n_q          <= 1'b1;
        end else begin
            start_q         <= start_sending;
            command_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!bus.RXF_N) begin
                        state_q <= StRdOe;
                    end else if (start_edge) begin
                        read_index_q <= IDX_W'(DEPTH - 1);
                        state_q      <= StCapture;
                    end
                end
                StCapture: begin
                    if (read_index_q == '0) begin
                        pending_q <= 1'b1;
                        state_q   <= StReady;
                    end else begin
                        read_index_q <= read_index_q - IDX_W'(1);
                    end
                end
                StReady: begin
                    if (!bus.RXF_N) begin
                        state_q <= StRdOe;
                    end else begin
                        tx_word_q  <= next_word;
                        word_cnt_q <= '0;
                        wr_n_q     <= 1'b0;
                        pending_q  <= 1'b0;
                        state_q    <= StSend;
                    end
                end
                StRdOe: begin
                    oe_n_q  <= 1'b0;
                    state_q <= StRdRd;
                end
                StRdRd: begin
                    rd_n_q  <= 1'b0;
                    state_q <= StRdCap;
                end
                StRdCap: begin
                    rx_word_q <= DATA;
                    state_q   <= StRdEnd;
                end
                StRdEnd: begin
                    oe_n_q          <= 1'b1;
                    rd_n_q          <= 1'b1;
                    command_q       <= rx_word_q;
                    command_valid_q <= 1'b1;
                    state_q         <= pending_q ? StReady : StIdle;
                end
                StSend: begin
                    if (!bus.TXE_N) begin
                        if (word_cnt_q == LAST_POS) begin
                            wr_n_q       <= 1'b1;
                            frame_done_q <= 1'b1;
                            state_q      <= StHold;
                        end else begin
                            word_cnt_q <= word_cnt_q + CNT_W'(1);
                            tx_word_q  <= next_word;
                        end
                    end
                end
                StHold: begin
                    if (!start_sending) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign read_index    = read_index_q;
    assign command       = command_q;
    assign command_valid = command_valid_q;
    assign frame_done    = frame_done_q;
    assign busy          = (state_q != StIdle);
    assign bus.OE_N      = oe_n_q;
    assign bus.RD_N      = rd_n_q;
    assign bus.WR_N      = wr_n_q;

    // The bus is ours whenever the host side is not output-enabled.
    assign DATA = oe_n_q ? tx_word_q : 16'hzzzz;
    assign BE   = oe_n_q ? 2'b11 : 2'bzz;

endmodule

// File: tb/tb_usb_frame_streamer.sv
// Directed bench for usb_frame_streamer (2 channels, depth 4) with an expected-word queue
// matched against words observed on the FIFO bus.
module tb_usb_frame_streamer;

    logic        clk;
    logic        reset;
    logic        start_sending;
    logic [31:0] data_in;
    logic [1:0]  read_index;
    logic [15:0] command;
    logic        command_valid;
    logic        busy;
    logic        frame_done;
    wire  [15:0] data_bus;
    wire  [1:0]  be_bus;
    logic [15:0] host_word;
    logic [15:0] base;

    usb_frame_streamer_if bus_if ();

    usb_frame_streamer #(
        .NUM_CH    (2),
        .DEPTH     (4),
        .SAMPLE_W  (16),
        .HEADER_EN (1),
        .HEADER    (16'hA5A5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_sending (start_sending),
        .data_in       (data_in),
        .read_index    (read_index),
        .command       (command),
        .command_valid (command_valid),
        .busy          (busy),
        .frame_done    (frame_done),
        .bus           (bus_if),
        .DATA          (data_bus),
        .BE            (be_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host bridge drives DATA only while it is output-enabled.
    assign data_bus = (bus_if.OE_N == 1'b0) ? host_word : 16'hzzzz;

    always_comb begin
        data_in = {base + 16'h0010 + {14'b0, read_index}, base + {14'b0, read_index}};
    end

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          rd_ptr;
    int          n_checks;
    int          n_fail;
    int          wr_low_cnt;
    int          done_cnt;
    int          cv_cnt;
    int          stall_err;
    logic        prev_stall;
    logic [15:0] prev_word;

    initial begin
        wr_low_cnt = 0;
        done_cnt   = 0;
        cv_cnt     = 0;
        stall_err  = 0;
        prev_stall = 1'b0;
        prev_word  = '0;
    end

    always @(negedge clk) begin
        if (bus_if.WR_N === 1'b0) begin
            wr_low_cnt++;
            if (prev_stall && (data_bus !== prev_word)) stall_err++;
            if (bus_if.TXE_N === 1'b0) obs_q.push_back(data_bus);
            prev_stall = (bus_if.TXE_N === 1'b1);
            prev_word  = data_bus;
        end else begin
            prev_stall = 1'b0;
        end
        if (frame_done === 1'b1) done_cnt++;
        if (command_valid === 1'b1) cv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] b);
        exp_q.push_back(16'hA5A5);
        for (int ch = 0; ch < 2; ch++) begin
            for (int idx = 3; idx >= 0; idx--) begin
                exp_q.push_back(b + 16'(ch * 16 + idx));
            end
        end
    endtask

    task automatic pulse_start();
        start_sending = 1'b1;
        tick();
        start_sending = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int k;
        k = 0;
        while ((done_cnt == d0) && (k < 200)) begin
            tick();
            k++;
        end
        tick();
        tick();
        check({tag, "_frame_done_count"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_obs(input string tag, input int n);
        int k;
        k = 0;
        while (((obs_q.size() - rd_ptr) < n) && (k < 100)) begin
            tick();
            k++;
        end
        check({tag, "_reach_word"}, 32'(obs_q.size() - rd_ptr), 32'(n));
    endtask

    task automatic drain(input string tag);
        logic [15:0] exp;
        logic [15:0] got;
        int          pos;
        pos = 0;
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            if (rd_ptr < obs_q.size()) begin
                got = obs_q[rd_ptr];
                rd_ptr++;
            end else begin
                got = 16'hxxxx;
            end
            check($sformatf("%s_word%0d", tag, pos), 32'(got), 32'(exp));
            pos++;
        end
        check({tag, "_extra_words"}, 32'(obs_q.size() - rd_ptr), 32'd0);
    endtask

    initial begin
        int d0;
        int w0;
        int cv0;
        int a0;
        int k;

        n_checks      = 0;
        n_fail        = 0;
        rd_ptr        = 0;
        reset         = 1'b0;
        start_sending = 1'b0;
        host_word     = 16'h0000;
        base          = 16'h0010;
        bus_if.TXE_N  = 1'b0;
        bus_if.RXF_N  = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_wr_n", 32'(bus_if.WR_N), 32'd1);
        check("rst_oe_n", 32'(bus_if.OE_N), 32'd1);
        check("rst_rd_n", 32'(bus_if.RD_N), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read_index", 32'(read_index), 32'd0);
        check("rst_command", 32'(command), 32'd0);
        check("rst_command_valid", 32'(command_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_data", 32'(data_bus), 32'd0);
        check("rst_be", 32'(be_bus), 32'd3);
        reset = 1'b1;
        tick();

        // T1: plain frame, no back-pressure
        base = 16'h0010;
        push_frame(base);
        d0 = done_cnt;
        w0 = wr_low_cnt;
        pulse_start();
        wait_done("t1", d0);
        check("t1_wr_low_cycles", 32'(wr_low_cnt - w0), 32'd9);
        drain("t1");
        check("t1_busy_after", 32'(busy), 32'd0);

        // T2: TXE_N high for 3 cycles after the 3rd accepted word
        base = 16'h0030;
        push_frame(base);
        d0 = done_cnt;
        w0 = wr_low_cnt;
        pulse_start();
        wait_obs("t2", 3);
        bus_if.TXE_N = 1'b1;
        repeat (3) tick();
        bus_if.TXE_N = 1'b0;
        wait_done("t2", d0);
        check("t2_wr_low_cycles", 32'(wr_low_cnt - w0), 32'd12);
        check("t2_stall_stable", 32'(stall_err), 32'd0);
        drain("t2");

        // T3: host command read from IDLE
        host_word    = 16'h0042;
        cv0          = cv_cnt;
        bus_if.RXF_N = 1'b0;
        k = 0;
        while ((bus_if.OE_N !== 1'b0) && (k < 20)) begin
            tick();
            k++;
        end
        check("t3_oe_low", 32'(bus_if.OE_N), 32'd0);
        check("t3_rd_high_first", 32'(bus_if.RD_N), 32'd1);
        tick();
        check("t3_rd_low", 32'(bus_if.RD_N), 32'd0);
        bus_if.RXF_N = 1'b1;
        k = 0;
        while ((cv_cnt == cv0) && (k < 20)) begin
            tick();
            k++;
        end
        tick();
        check("t3_command", 32'(command), 32'h0042);
        check("t3_cv_pulses", 32'(cv_cnt - cv0), 32'd1);
        check("t3_cv_low_after", 32'(command_valid), 32'd0);
        check("t3_oe_released", 32'(bus_if.OE_N), 32'd1);
        check("t3_rd_released", 32'(bus_if.RD_N), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);

        // T4: command arrives while the frame is ready
        base = 16'h0050;
        push_frame(base);
        d0  = done_cnt;
        cv0 = cv_cnt;
        a0  = obs_q.size();
        pulse_start();
        k = 0;
        while (!((busy === 1'b1) && (read_index == 2'd0)) && (k < 20)) begin
            tick();
            k++;
        end
        host_word    = 16'h0077;
        bus_if.RXF_N = 1'b0;
        k = 0;
        while ((bus_if.RD_N !== 1'b0) && (k < 20)) begin
            tick();
            k++;
        end
        bus_if.RXF_N = 1'b1;
        k = 0;
        while ((cv_cnt == cv0) && (k < 20)) begin
            tick();
            k++;
        end
        check("t4_command", 32'(command), 32'h0077);
        check("t4_no_words_before_cmd", 32'(obs_q.size() - a0), 32'd0);
        wait_done("t4", d0);
        check("t4_cv_pulses", 32'(cv_cnt - cv0), 32'd1);
        drain("t4");

        // T5: reset during the 3rd word, then a fresh frame
        base = 16'h0060;
        push_frame(base);
        pulse_start();
        wait_obs("t5", 2);
        reset = 1'b0;
        @(negedge clk);
        check("t5_wr_n", 32'(bus_if.WR_N), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_oe_n", 32'(bus_if.OE_N), 32'd1);
        check("t5_data", 32'(data_bus), 32'd0);
        exp_q.delete();
        rd_ptr = obs_q.size();
        tick();
        reset = 1'b1;
        tick();
        base = 16'h0070;
        push_frame(base);
        d0 = done_cnt;
        pulse_start();
        wait_done("t5_fresh", d0);
        drain("t5_fresh");

        // T6: start held high sends one frame only; a new rising edge sends one more
        base = 16'h0080;
        push_frame(base);
        d0 = done_cnt;
        start_sending = 1'b1;
        wait_done("t6a", d0);
        repeat (30) tick();
        check("t6a_single_frame", 32'(done_cnt - d0), 32'd1);
        check("t6a_hold_busy", 32'(busy), 32'd1);
        drain("t6a");
        start_sending = 1'b0;
        tick();
        tick();
        check("t6_idle_after_release", 32'(busy), 32'd0);
        base = 16'h0090;
        push_frame(base);
        d0 = done_cnt;
        start_sending = 1'b1;
        wait_done("t6b", d0);
        repeat (30) tick();
        check("t6b_single_frame", 32'(done_cnt - d0), 32'd1);
        drain("t6b");
        start_sending = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
